// File: rtl/ctr_mode_pkg.sv
// Shared widths and FSM encoding for the CTR-mode controller.
// Imported by the controller top and its counter sub-module.
package ctr_mode_pkg;

    localparam int KEY_W     = 80;
    localparam int BLK_W     = 64;
    localparam int CTR_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IN = 2'd1,
        RUN     = 2'd2,
        DRAIN   = 2'd3
    } state_t;

endpackage

// File: rtl/ctr_mode_ctrl_ctr_reg.sv
// Block counter with clear, increment and sticky wrap flag.
// The flag sets when an all-ones count increments back to zero.
module ctr_reg
    import ctr_mode_pkg::*;
#(
    parameter int W = CTR_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (clr) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (inc) begin
            count <= count + W'(1);
            if (&count) wrap <= 1'b1;
        end
    end

endmodule

// File: rtl/ctr_mode_ctrl.sv
// CTR-mode controller: sequences one external block-encrypt per word
// and XORs the keystream with the captured plaintext.
module ctr_mode_ctrl
    import ctr_mode_pkg::*;
#(
    parameter int CTR_W = CTR_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [KEY_W-1:0]       key,
    input  logic [BLK_W-CTR_W-1:0] nonce,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BLK_W-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BLK_W-1:0]       out_data,
    output logic                   enc_req,
    input  logic                   enc_ack,
    output logic [KEY_W-1:0]       enc_K,
    output logic [BLK_W-1:0]       enc_M,
    input  logic [BLK_W-1:0]       enc_C,
    output logic                   ctr_wrap
);

    localparam int NONCE_W = BLK_W - CTR_W;

    state_t             state;
    logic [KEY_W-1:0]   key_reg;
    logic [NONCE_W-1:0] nonce_reg;
    logic [BLK_W-1:0]   data_reg;
    logic [BLK_W-1:0]   out_reg;
    logic [CTR_W-1:0]   ctr;
    logic               load;
    logic               bump;

    // start is honoured only while no block is in flight
    assign load = start && (state == IDLE || state == WAIT_IN);
    assign bump = (state == RUN) && enc_ack;

    ctr_reg #(.W(CTR_W)) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (load),
        .inc   (bump),
        .count (ctr),
        .wrap  (ctr_wrap)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            key_reg   <= '0;
            nonce_reg <= '0;
            data_reg  <= '0;
            out_reg   <= '0;
            enc_req   <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        key_reg   <= key;
                        nonce_reg <= nonce;
                        in_ready  <= 1'b1;
                        state     <= WAIT_IN;
                    end
                end
                WAIT_IN: begin
                    if (start) begin
                        key_reg   <= key;
                        nonce_reg <= nonce;
                    end else if (in_valid) begin
                        data_reg <= in_data;
                        in_ready <= 1'b0;
                        enc_req  <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (enc_ack) begin
                        out_reg   <= enc_C ^ data_reg;
                        enc_req   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= WAIT_IN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign enc_K    = key_reg;
    assign enc_M    = {nonce_reg, ctr};
    assign out_data = out_reg;

endmodule

// File: tb/tb_ctr_mode_ctrl.sv
// Directed bench: two controllers (32-bit and 4-bit counter) against
// a behavioural encryptor stub with known cipher vectors.
module tb_ctr_mode_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    // ---- DUT 0: default 32-bit counter
    logic        start0 = 0, in_valid0 = 0, out_ready0 = 0;
    logic [79:0] key0 = '0;
    logic [31:0] nonce0 = '0;
    logic [63:0] in_data0 = '0;
    logic        in_ready0, out_valid0, enc_req0, wrap0;
    logic        ack0 = 1'b0;
    logic [63:0] out_data0, enc_M0, enc_C0;
    logic [79:0] enc_K0;
    int          acnt0 = 0;

    // ---- DUT 1: 4-bit counter for the wrap boundary
    logic        start1 = 0, in_valid1 = 0, out_ready1 = 0;
    logic [79:0] key1 = '0;
    logic [59:0] nonce1 = '0;
    logic [63:0] in_data1 = '0;
    logic        in_ready1, out_valid1, enc_req1, wrap1;
    logic        ack1 = 1'b0;
    logic [63:0] out_data1, enc_M1, enc_C1;
    logic [79:0] enc_K1;
    int          acnt1 = 0;

    ctr_mode_ctrl dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .key(key0),
        .nonce(nonce0), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_data(in_data0), .out_valid(out_valid0),
        .out_ready(out_ready0), .out_data(out_data0),
        .enc_req(enc_req0), .enc_ack(ack0), .enc_K(enc_K0),
        .enc_M(enc_M0), .enc_C(enc_C0), .ctr_wrap(wrap0)
    );

    ctr_mode_ctrl #(.CTR_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .key(key1),
        .nonce(nonce1), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_data(out_data1),
        .enc_req(enc_req1), .enc_ack(ack1), .enc_K(enc_K1),
        .enc_M(enc_M1), .enc_C(enc_C1), .ctr_wrap(wrap1)
    );

    // Encryptor stub: two reference vectors, arbitrary mix otherwise
    function automatic logic [63:0] cipher(input logic [79:0] k,
                                           input logic [63:0] m);
        logic [79:0] ones;
        ones = '1;
        if (k == 80'd0 && m == 64'd0) return 64'h5579C1387B228445;
        if (k == ones && m == 64'd0) return 64'hE72C46C0F5945049;
        return m ^ k[63:0] ^ 64'hA5A50F0F3C3C9696;
    endfunction

    assign enc_C0 = cipher(enc_K0, enc_M0);
    assign enc_C1 = cipher(enc_K1, enc_M1);

    // ack after a few cycles of req, held until req drops
    always @(posedge clk) begin
        if (!enc_req0) begin
            acnt0 <= 0;
            ack0  <= 1'b0;
        end else if (acnt0 < 2) acnt0 <= acnt0 + 1;
        else ack0 <= 1'b1;
    end

    always @(posedge clk) begin
        if (!enc_req1) begin
            acnt1 <= 0;
            ack1  <= 1'b0;
        end else if (acnt1 < 2) acnt1 <= acnt1 + 1;
        else ack1 <= 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs,
                       input logic [79:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic send0(input logic [63:0] d);
        in_data0  = d;
        in_valid0 = 1'b1;
        step();
        in_valid0 = 1'b0;
    endtask

    task automatic wait_out0();
        int n;
        n = 0;
        while (!out_valid0 && n < 20) begin
            step();
            n++;
        end
        chk("d0_out_valid_timeout", {79'd0, out_valid0}, 80'd1);
    endtask

    task automatic wait_out1();
        int n;
        n = 0;
        while (!out_valid1 && n < 20) begin
            step();
            n++;
        end
        chk("d1_out_valid_timeout", {79'd0, out_valid1}, 80'd1);
    endtask

    task automatic drain0();
        out_ready0 = 1'b1;
        step();
        out_ready0 = 1'b0;
    endtask

    task automatic word1();
        in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        wait_out1();
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
    endtask

    initial begin
        logic [79:0] ones;
        logic [79:0] k2;
        logic [63:0] exp2;
        ones = '1;
        k2   = 80'h0123_4567_89AB_CDEF_1357;

        step();
        step();
        chk("rst_in_ready", {79'd0, in_ready0}, 80'd0);
        chk("rst_out_valid", {79'd0, out_valid0}, 80'd0);
        chk("rst_enc_req", {79'd0, enc_req0}, 80'd0);
        chk("rst_out_data", {16'd0, out_data0}, 80'd0);
        chk("rst_wrap", {79'd0, wrap0}, 80'd0);
        chk("rst_enc_K", enc_K0, 80'd0);
        chk("rst_enc_M", {16'd0, enc_M0}, 80'd0);
        rst_n = 1'b1;
        step();
        chk("idle_in_ready", {79'd0, in_ready0}, 80'd0);

        // key 0, nonce 0 reference vector
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        chk("wait_in_ready", {79'd0, in_ready0}, 80'd1);
        send0(64'd0);
        chk("run_enc_req", {79'd0, enc_req0}, 80'd1);
        chk("run_in_ready", {79'd0, in_ready0}, 80'd0);
        chk("run0_enc_M", {16'd0, enc_M0}, 80'd0);
        wait_out0();
        chk("v0_out_data", {16'd0, out_data0}, {16'd0, 64'h5579C1387B228445});
        chk("drain_enc_req", {79'd0, enc_req0}, 80'd0);
        drain0();
        chk("hs_out_valid", {79'd0, out_valid0}, 80'd0);
        chk("hs_in_ready", {79'd0, in_ready0}, 80'd1);

        // all-ones key reference vector, reload from WAIT_IN
        key0   = ones;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        chk("reload_ctr", {16'd0, enc_M0}, 80'd0);
        send0(64'd0);
        chk("run1_enc_K", enc_K0, ones);
        wait_out0();
        chk("v1_out_data", {16'd0, out_data0}, {16'd0, 64'hE72C46C0F5945049});
        drain0();

        // second word: counter advanced to 1
        send0(64'h0123456789ABCDEF);
        chk("run2_enc_M", {16'd0, enc_M0}, 80'd1);
        exp2 = 64'h0123456789ABCDEF ^ 64'h1 ^ 64'hFFFFFFFFFFFFFFFF
               ^ 64'hA5A50F0F3C3C9696;
        step();
        chk("run2_enc_M_stable", {16'd0, enc_M0}, 80'd1);
        chk("run2_enc_req_held", {79'd0, enc_req0}, 80'd1);
        wait_out0();
        chk("v2_out_data", {16'd0, out_data0}, {16'd0, exp2});

        // back-pressure: 10 cycles in DRAIN, start ignored
        start0 = 1'b1;
        key0   = k2;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_out_data", {16'd0, out_data0}, {16'd0, exp2});
            chk("bp_out_valid", {79'd0, out_valid0}, 80'd1);
            chk("bp_in_ready", {79'd0, in_ready0}, 80'd0);
            chk("bp_enc_req", {79'd0, enc_req0}, 80'd0);
        end
        start0 = 1'b0;
        chk("drain_start_ignored", enc_K0, ones);
        drain0();

        // start and in_valid together: reload wins, no capture
        nonce0    = 32'hCAFEBABE;
        start0    = 1'b1;
        in_valid0 = 1'b1;
        in_data0  = 64'h1111;
        step();
        start0    = 1'b0;
        in_valid0 = 1'b0;
        chk("collide_enc_K", enc_K0, k2);
        chk("collide_enc_M", {16'd0, enc_M0}, {16'd0, 64'hCAFEBABE_00000000});
        chk("collide_in_ready", {79'd0, in_ready0}, 80'd1);
        step();
        chk("collide_no_req", {79'd0, enc_req0}, 80'd0);

        // start ignored in RUN
        send0(64'h2222);
        start0 = 1'b1;
        key0   = 80'd5;
        step();
        start0 = 1'b0;
        chk("run_start_ignored", enc_K0, k2);

        // reset mid-RUN
        chk("pre_rst_enc_req", {79'd0, enc_req0}, 80'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_enc_req", {79'd0, enc_req0}, 80'd0);
        chk("midrst_out_valid", {79'd0, out_valid0}, 80'd0);
        chk("midrst_in_ready", {79'd0, in_ready0}, 80'd0);
        chk("midrst_enc_K", enc_K0, 80'd0);
        out_ready0 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("midrst_no_out", {79'd0, out_valid0}, 80'd0);
        end
        out_ready0 = 1'b0;

        // wrap on the 4-bit counter instance
        nonce1 = 60'hABCDEF012345678;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int i = 0; i < 15; i++) word1();
        chk("pre_wrap_ctr", {16'd0, enc_M1}, {16'd0, 64'hABCDEF012345678F});
        chk("pre_wrap_flag", {79'd0, wrap1}, 80'd0);
        word1();
        chk("wrap_ctr", {16'd0, enc_M1}, {16'd0, 64'hABCDEF0123456780});
        chk("wrap_flag", {79'd0, wrap1}, 80'd1);
        word1();
        chk("wrap_sticky", {79'd0, wrap1}, 80'd1);
        chk("post_wrap_ctr", {16'd0, enc_M1}, {16'd0, 64'hABCDEF0123456781});
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        chk("start_clears_wrap", {79'd0, wrap1}, 80'd0);
        chk("start_clears_ctr", {16'd0, enc_M1}, {16'd0, 64'hABCDEF0123456780});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ctr_mode_ctrl.md
CTR_MODE_CTRL -- requirements
Module: ctr_mode_ctrl

Interface
REQ-001 Parameter CTR_W, default 32: counter width; the nonce width SHALL be 64-CTR_W.
REQ-002 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-003 rst_n  input  1  synchronous, active-low reset; sampled only on posedge clk.
REQ-004 start  input  1  load key and nonce, clear counter.
REQ-005 key  input  80  cipher key, sampled on an accepted start.
REQ-006 nonce  input  64-CTR_W  upper field of the counter block, sampled on an accepted start.
REQ-007 in_valid / in_ready  input / output  1 / 1  plaintext word handshake.
REQ-008 in_data  input  64  plaintext word.
REQ-009 out_valid / out_ready  output / input  1 / 1  ciphertext word handshake.
REQ-010 out_data  output  64  ciphertext word = in_data XOR keystream.
REQ-011 enc_req  output  1  request to the encryptor; held high until enc_ack.
REQ-012 enc_ack  input  1  encryptor done; enc_C is valid while it is high.
REQ-013 enc_K / enc_M  output / output  80 / 64  encryptor key and counter block.
REQ-014 enc_C  input  64  encryptor result.
REQ-015 ctr_wrap  output  1  sticky flag: the counter wrapped.

Function
REQ-016 FSM states SHALL be IDLE, WAIT_IN, RUN and DRAIN.
REQ-017 IDLE: in_ready=0; start -> WAIT_IN, latching key and nonce, counter cleared to 0, ctr_wrap cleared.
REQ-018 WAIT_IN: in_ready=1; if in_valid, capture in_data -> RUN; start in WAIT_IN reloads key/nonce/counter and takes priority over in_valid, so no capture that cycle.
REQ-019 RUN: enc_req=1, enc_M={nonce_reg, ctr}, enc_K=key_reg; all three SHALL be stable for the whole of RUN.
REQ-020 RUN with enc_ack=1: out_reg <= enc_C XOR data_reg, ctr <= ctr+1 (mod 2^CTR_W) -> DRAIN.
REQ-021 Counter wrap: when ctr is all-ones and increments to 0, ctr_wrap SHALL set and hold until start or reset.
REQ-022 DRAIN: enc_req=0, out_valid=1, out_data=out_reg stable; out_ready -> WAIT_IN; otherwise stay in DRAIN.
REQ-023 enc_req SHALL be low for at least one cycle between consecutive requests, because the encryptor rearms on req low.
REQ-024 start SHALL be ignored in RUN and DRAIN.
REQ-025 Latency: out_valid rises 1 cycle after the enc_ack edge; in_ready is low from in acceptance until the cycle after the out handshake.
REQ-026 enc_ack outside RUN SHALL be ignored.

Reset
REQ-027 On rst_n=0 at posedge clk the block SHALL go to IDLE, with enc_req=0, in_ready=0, out_valid=0, out_data=0, ctr=0, ctr_wrap=0, key_reg=0 and nonce_reg=0.
REQ-028 Reset during RUN SHALL drop enc_req in the next cycle and discard the pending result.

Structure
REQ-029 A shared package SHALL hold KEY_W=80, BLK_W=64, the default CTR_W and the FSM state encoding.
REQ-030 A single sub-module, ctr_reg, SHALL implement the CTR_W counter with increment and wrap-flag output; there SHALL be no other sub-modules.
REQ-031 The encryptor SHALL be instantiated outside this block; the link is the enc_* ports only.

Verification
REQ-032 Stimulus: key=0, nonce=0, start, then in_data=0. Response: enc_M=0 and out_data=5579C1387B228445.
REQ-033 Stimulus: key=all-F, nonce=0, start, then in_data=0. Response: out_data=E72C46C0F5945049; a second word gives enc_M=0000000000000001.
REQ-034 Stimulus: out_ready held low for 10 cycles in DRAIN. Response: out_data stable, in_ready=0, enc_req=0 throughout.
REQ-035 Stimulus: counter preloaded to FFFFFFFF and one word sent. Response: next enc_M low half=00000000 and ctr_wrap=1; start clears ctr_wrap.
REQ-036 Stimulus: rst_n low mid-RUN. Response: IDLE next cycle, enc_req=0, out_valid=0, and no out handshake follows.
REQ-037 Stimulus: start and in_valid in the same WAIT_IN cycle. Response: reload only, no capture, counter=0.
